// File: rtl/game_state_ctrl.sv
// Frogger game-flow controller: start, play, death/win pauses, game over.
// Optional score register enabled by defining GAME_SCORE_EN.
module game_state_ctrl #(
    parameter int LIVES_INIT    = 3,
    parameter int MAX_LEVEL     = 9,
    parameter int FREEZE_CYCLES = 25000000,
    parameter int TIMER_W       = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       death_collision,
    input  logic       win_collision,
    input  logic       start_btn,
    output logic       frog_respawn,
    output logic       freeze,
    output logic [2:0] lives,
    output logic [3:0] level,
    output logic       game_over,
    output logic [2:0] state,
    output logic [7:0] score
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PLAY      = 3'd1,
        DEATH     = 3'd2,
        WIN       = 3'd3,
        GAME_OVER = 3'd4
    } state_t;

    localparam logic [2:0]         LIVES_LD  = 3'(LIVES_INIT);
    localparam logic [3:0]         LEVEL_MAX = 4'(MAX_LEVEL);
    localparam logic [TIMER_W-1:0] T_LAST    = TIMER_W'(FREEZE_CYCLES - 1);

    state_t             st;
    logic               start_q;
    logic [TIMER_W-1:0] timer;
    logic               start_rise;
    logic               sample;
    logic               pause_done;
    logic               hit_death;
    logic               hit_win;

    assign start_rise = start_btn & ~start_q;
    // Flags seen on the respawn cycle still describe the frog's old position.
    assign sample     = frame_tick & ~frog_respawn;
    assign hit_death  = (st == PLAY) & sample & death_collision;
    assign hit_win    = (st == PLAY) & sample & ~death_collision & win_collision;
    assign pause_done = (timer == T_LAST);
    assign state      = st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= 1'b1;
        end else begin
            start_q <= start_btn;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st           <= IDLE;
            freeze       <= 1'b1;
            frog_respawn <= 1'b0;
            game_over    <= 1'b0;
            lives        <= 3'd0;
            level        <= 4'd0;
            timer        <= '0;
        end else begin
            frog_respawn <= 1'b0;
            case (st)
                IDLE, GAME_OVER: begin
                    timer  <= '0;
                    freeze <= 1'b1;
                    game_over <= (st == GAME_OVER);
                    if (start_rise) begin
                        st           <= PLAY;
                        lives        <= LIVES_LD;
                        level        <= 4'd1;
                        freeze       <= 1'b0;
                        game_over    <= 1'b0;
                        frog_respawn <= 1'b1;
                    end
                end
                PLAY: begin
                    timer     <= '0;
                    freeze    <= 1'b0;
                    game_over <= 1'b0;
                    if (hit_death) begin
                        lives  <= (lives == 3'd0) ? 3'd0 : lives - 3'd1;
                        st     <= DEATH;
                        freeze <= 1'b1;
                    end else if (hit_win) begin
                        level  <= (level >= LEVEL_MAX) ? LEVEL_MAX
                                                       : level + 4'd1;
                        st     <= WIN;
                        freeze <= 1'b1;
                    end
                end
                DEATH, WIN: begin
                    freeze    <= 1'b1;
                    game_over <= 1'b0;
                    if (pause_done) begin
                        timer <= '0;
                        if (st == DEATH && lives == 3'd0) begin
                            st        <= GAME_OVER;
                            game_over <= 1'b1;
                        end else begin
                            st           <= PLAY;
                            freeze       <= 1'b0;
                            frog_respawn <= 1'b1;
                        end
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                default: begin
                    st        <= IDLE;
                    freeze    <= 1'b1;
                    game_over <= 1'b0;
                    timer     <= '0;
                end
            endcase
        end
    end

`ifdef GAME_SCORE_EN
    logic [7:0] score_q;
    logic [8:0] score_sum;

    assign score_sum = {1'b0, score_q} + {5'd0, level};
    assign score     = score_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score_q <= 8'd0;
        end else if ((st == IDLE || st == GAME_OVER) && start_rise) begin
            score_q <= 8'd0;
        end else if (hit_win) begin
            score_q <= score_sum[8] ? 8'hff : score_sum[7:0];
        end
    end
`else
    assign score = 8'd0;
`endif

endmodule
